// File: rtl/adpll_lock_ctrl_if.sv
// Request channel of the ADPLL lock controller: M request handshake plus the
// reject pulse for illegal (zero) factors.
interface adpll_lock_ctrl_if;
  logic       REQ_VALID;
  logic [2:0] REQ_M;
  logic       REQ_READY;
  logic       REQ_ERR;

  modport master (
    output REQ_VALID,
    output REQ_M,
    input  REQ_READY,
    input  REQ_ERR
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_M,
    output REQ_READY,
    output REQ_ERR
  );
endinterface

// File: rtl/adpll_lock_ctrl.sv
// ADPLL lock sequencer: applies M, pulses the ADPLL reset, waits for a stable
// LOCK within a timeout, retries a bounded number of times and watches for loss of lock.
module adpll_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned LOL_CYCLES    = 8,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                    REF_CLK,
  input  logic                    RESET,
  adpll_lock_ctrl_if.slave        req,
  input  logic                    LOCK,
  output logic [2:0]              M,
  output logic                    PLL_RST,
  output logic                    READY,
  output logic                    FAIL,
  output logic                    LOL
);

  localparam int unsigned RstW    = $clog2(RST_CYCLES + 1);
  localparam int unsigned TimerW  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned StableW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned LowW    = $clog2(LOL_CYCLES + 1);
  localparam int unsigned RetryW  = $clog2(MAX_RETRY + 1);

  localparam logic [RstW-1:0]    RstLast    = RstW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0]  TimerLast  = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0]  TimerMax   = TimerW'(LOCK_TIMEOUT);
  localparam logic [StableW-1:0] StableLast = StableW'(STABLE_CYCLES - 1);
  localparam logic [StableW-1:0] StableMax  = StableW'(STABLE_CYCLES);
  localparam logic [LowW-1:0]    LowLast    = LowW'(LOL_CYCLES - 1);
  localparam logic [LowW-1:0]    LowMax     = LowW'(LOL_CYCLES);
  localparam logic [RetryW-1:0]  RetryMax   = RetryW'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle,
    StPllRst,
    StAcquire,
    StConfirm,
    StLocked,
    StFailed
  } state_e;

  state_e               state_q, state_d;
  logic [RstW-1:0]      rst_cnt_q, rst_cnt_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [StableW-1:0]   stable_q, stable_d;
  logic [LowW-1:0]      low_q, low_d;
  logic [RetryW-1:0]    retry_q, retry_d;
  logic [2:0]           m_d;
  logic                 req_err_d, lol_d;
  logic                 accept;
  logic [RetryW-1:0]    retry_inc;
  logic [TimerW-1:0]    timer_inc;

  assign accept    = req.REQ_VALID && req.REQ_READY;
  assign retry_inc = (retry_q >= RetryMax) ? retry_q : retry_q + RetryW'(1);
  assign timer_inc = (timer_q >= TimerMax) ? timer_q : timer_q + TimerW'(1);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    timer_d   = timer_q;
    stable_d  = stable_q;
    low_d     = low_q;
    retry_d   = retry_q;
    m_d       = M;
    req_err_d = 1'b0;
    lol_d     = 1'b0;

    unique case (state_q)
      StIdle, StFailed: ;
      StPllRst: begin
        if (rst_cnt_q >= RstLast) begin
          state_d = StAcquire;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StAcquire: begin
        timer_d = timer_inc;
        // Lock completion wins over a timeout landing in the same cycle.
        if (LOCK && (STABLE_CYCLES == 1)) begin
          state_d = StLocked;
        end else if (timer_q >= TimerLast) begin
          retry_d = retry_inc;
          state_d = (retry_inc < RetryMax) ? StPllRst : StFailed;
        end else if (LOCK) begin
          state_d  = StConfirm;
          stable_d = StableW'(1);
        end
      end
      StConfirm: begin
        timer_d = timer_inc;
        if (LOCK && (stable_q >= StableLast)) begin
          state_d = StLocked;
        end else if (timer_q >= TimerLast) begin
          retry_d = retry_inc;
          state_d = (retry_inc < RetryMax) ? StPllRst : StFailed;
        end else if (LOCK) begin
          stable_d = (stable_q >= StableMax) ? stable_q : stable_q + StableW'(1);
        end else begin
          state_d  = StAcquire;
          stable_d = '0;
        end
      end
      StLocked: begin
        low_d = LOCK ? '0 : ((low_q >= LowMax) ? low_q : low_q + LowW'(1));
        if (!LOCK && (low_q >= LowLast)) begin
          lol_d   = 1'b1;
          retry_d = '0;
          state_d = StPllRst;
        end
      end
      default: state_d = StIdle;
    endcase

    // An accepted request overrides loss of lock; a zero factor only reports an error.
    if (accept) begin
      lol_d = 1'b0;
      if (req.REQ_M != 3'd0) begin
        m_d     = req.REQ_M;
        retry_d = '0;
        state_d = StPllRst;
      end else begin
        req_err_d = 1'b1;
        retry_d   = retry_q;
        state_d   = state_q;
      end
    end

    if ((state_d == StPllRst) && ((state_q != StPllRst) || accept)) begin
      rst_cnt_d = '0;
      timer_d   = '0;
      stable_d  = '0;
    end
    if ((state_d == StLocked) && (state_q != StLocked)) begin
      low_d = '0;
    end
  end

  always_ff @(posedge REF_CLK) begin
    if (RESET) begin
      state_q       <= StIdle;
      rst_cnt_q     <= '0;
      timer_q       <= '0;
      stable_q      <= '0;
      low_q         <= '0;
      retry_q       <= '0;
      M             <= 3'd0;
      PLL_RST       <= 1'b1;
      req.REQ_READY <= 1'b1;
      READY         <= 1'b0;
      FAIL          <= 1'b0;
      req.REQ_ERR   <= 1'b0;
      LOL           <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      timer_q       <= timer_d;
      stable_q      <= stable_d;
      low_q         <= low_d;
      retry_q       <= retry_d;
      M             <= m_d;
      PLL_RST       <= (state_d == StIdle) || (state_d == StPllRst) || (state_d == StFailed);
      req.REQ_READY <= (state_d == StIdle) || (state_d == StLocked) || (state_d == StFailed);
      READY         <= (state_d == StLocked);
      FAIL          <= (state_d == StFailed);
      req.REQ_ERR   <= req_err_d;
      LOL           <= lol_d;
    end
  end

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Directed bench for adpll_lock_ctrl: a short vector table plus cycle-accurate
// sequences for lock, glitch, retry/fail, loss of lock and request priority.
module tb_adpll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic [2:0] m;
  logic       pll_rst, ready, fail, lol;
  logic [8:0] obs;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  adpll_lock_ctrl_if req_if ();

  adpll_lock_ctrl #(
    .LOCK_TIMEOUT(64)
  ) dut (
    .REF_CLK(clk),
    .RESET  (rst),
    .req    (req_if),
    .LOCK   (lock),
    .M      (m),
    .PLL_RST(pll_rst),
    .READY  (ready),
    .FAIL   (fail),
    .LOL    (lol)
  );

  // {M, PLL_RST, REQ_READY, READY, FAIL, REQ_ERR, LOL}
  assign obs = {m, pll_rst, req_if.REQ_READY, ready, fail, req_if.REQ_ERR, lol};

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] rm;
    logic       lk;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [8:0] pk(input logic [2:0] em, input logic pr, input logic rr,
                                    input logic rdy, input logic f, input logic err,
                                    input logic l);
    return {em, pr, rr, rdy, f, err, l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int cyc, input logic [8:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got {m,prst,rrdy,rdy,fail,err,lol}=%b want %b",
               name, cyc, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    req_if.REQ_VALID = 1'b0;
    req_if.REQ_M     = 3'd0;
    lock             = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic go_locked(input logic [2:0] fm);
    do_reset();
    req_if.REQ_VALID = 1'b1;
    req_if.REQ_M     = fm;
    lock             = 1'b1;
    tick();
    req_if.REQ_VALID = 1'b0;
    for (int i = 0; i < 40 && !ready; i++) tick();
    chk1("go_locked_ready", ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'd0, 1'b0, pk(3'd0, 1, 1, 0, 0, 0, 0)};
    vecs[1] = '{1'b0, 1'b1, 3'd0, 1'b0, pk(3'd0, 1, 1, 0, 0, 1, 0)};
    vecs[2] = '{1'b0, 1'b0, 3'd0, 1'b0, pk(3'd0, 1, 1, 0, 0, 0, 0)};
    vecs[3] = '{1'b0, 1'b1, 3'd6, 1'b0, pk(3'd6, 1, 0, 0, 0, 0, 0)};
    vecs[4] = '{1'b0, 1'b1, 3'd2, 1'b0, pk(3'd6, 1, 0, 0, 0, 0, 0)};
    vecs[5] = '{1'b0, 1'b0, 3'd0, 1'b0, pk(3'd6, 1, 0, 0, 0, 0, 0)};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 1'b0, pk(3'd6, 1, 0, 0, 0, 0, 0)};
    vecs[7] = '{1'b0, 1'b0, 3'd0, 1'b0, pk(3'd6, 0, 0, 0, 0, 0, 0)};
    vecs[8] = '{1'b1, 1'b0, 3'd0, 1'b1, pk(3'd0, 1, 1, 0, 0, 0, 0)};

    rst              = 1'b1;
    req_if.REQ_VALID = 1'b0;
    req_if.REQ_M     = 3'd0;
    lock             = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rst              = vecs[i].rst;
      req_if.REQ_VALID = vecs[i].valid;
      req_if.REQ_M     = vecs[i].rm;
      lock             = vecs[i].lk;
      tick();
      chk("table", i, vecs[i].exp);
    end

    // Nominal lock, then short and long LOCK drops.
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) chk("nominal", c, pk(3'd3, c <= 4, c >= 41, c >= 41, 0, 0, 0));
      req_if.REQ_VALID = (c == 0);
      req_if.REQ_M     = 3'd3;
      lock             = (c >= 25);
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      lock = (c >= 7);
      tick();
      chk("lol_short", c, pk(3'd3, 0, 1, 1, 0, 0, 0));
    end
    lock = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c < 8)       chk("lol_long", c, pk(3'd3, 0, 1, 1, 0, 0, 0));
      else if (c == 8) chk("lol_long", c, pk(3'd3, 1, 0, 0, 0, 0, 1));
      else             chk("lol_long", c, pk(3'd3, 1, 0, 0, 0, 0, 0));
    end

    // Glitchy lock: one low sample in CONFIRM restarts the stable count.
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) chk("glitch", c, pk(3'd1, c <= 4, c >= 47, c >= 47, 0, 0, 0));
      req_if.REQ_VALID = (c == 0);
      req_if.REQ_M     = 3'd1;
      lock             = ((c >= 20) && (c <= 29)) || (c >= 31);
      tick();
    end

    // Reset held for two cycles in the middle of CONFIRM.
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      if (c > 0 && c <= 30) chk("rst_mid", c, pk(3'd3, c <= 4, 0, 0, 0, 0, 0));
      else if (c > 30)      chk("rst_mid", c, pk(3'd0, 1, 1, 0, 0, 0, 0));
      req_if.REQ_VALID = (c == 0);
      req_if.REQ_M     = 3'd3;
      lock             = (c >= 25);
      rst              = (c == 30) || (c == 31);
      tick();
    end
    rst = 1'b0;

    // Three timed-out attempts end in FAILED; a legal request restarts.
    do_reset();
    for (int c = 0; c <= 210; c++) begin
      if (c > 0) begin
        automatic logic f  = (c >= 205);
        automatic logic pr = (c <= 4) || ((c >= 69) && (c <= 72)) ||
                             ((c >= 137) && (c <= 140)) || f;
        chk("retry", c, pk(3'd5, pr, f, 0, f, 0, 0));
      end
      req_if.REQ_VALID = (c == 0) || (c == 210);
      req_if.REQ_M     = (c == 0) ? 3'd5 : 3'd7;
      lock             = 1'b0;
      tick();
    end
    req_if.REQ_VALID = 1'b0;
    chk("fail_exit", 211, pk(3'd7, 1, 0, 0, 0, 0, 0));

    // Zero factor in LOCKED is rejected without disturbing lock.
    go_locked(3'd4);
    req_if.REQ_VALID = 1'b1;
    req_if.REQ_M     = 3'd0;
    tick();
    req_if.REQ_VALID = 1'b0;
    chk("req_err", 1, pk(3'd4, 0, 1, 1, 0, 1, 0));
    tick();
    chk("req_err", 2, pk(3'd4, 0, 1, 1, 0, 0, 0));

    // Legal request in the cycle loss of lock would fire takes priority.
    lock = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      req_if.REQ_VALID = (c == 7);
      req_if.REQ_M     = 3'd2;
      tick();
      if (c < 7) chk("prio_wait", c + 1, pk(3'd4, 0, 1, 1, 0, 0, 0));
    end
    req_if.REQ_VALID = 1'b0;
    chk("prio", 8, pk(3'd2, 1, 0, 0, 0, 0, 0));
    tick();
    chk("prio", 9, pk(3'd2, 1, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
